// File: rtl/dma_if.sv
// rtl/dma_if.sv - DMA controller command, bus-grant and memory-port handshake bundle
interface dma_if #(
  parameter int WORD_SIZE = 16,
  parameter int CNT_W     = 4
);
  logic                 cmd_valid;
  logic [WORD_SIZE-1:0] cmd_addr;
  logic                 BR;
  logic                 BG;
  logic [CNT_W-1:0]     dev_index;
  logic [WORD_SIZE-1:0] dev_data;
  logic                 writeM2;
  logic                 mem_ack;
  logic                 dma_end_interrupt;
  logic                 busy;

  modport master (
    input  cmd_valid, cmd_addr, BG, dev_data, mem_ack,
    output BR, dev_index, writeM2, dma_end_interrupt, busy
  );

  modport slave (
    output cmd_valid, cmd_addr, BG, dev_data, mem_ack,
    input  BR, dev_index, writeM2, dma_end_interrupt, busy
  );
endinterface

// File: rtl/dma_controller.sv
// rtl/dma_controller.sv - BR/BG bus-master DMA copying LENGTH device words into memory
// The tri-stated address2/data2 stay plain ports so the shared memory port resolves outside the bundle.
module dma_controller #(
  parameter int WORD_SIZE = 16,
  parameter int LENGTH    = 12,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  dma_if.master                bus,
  output wire  [WORD_SIZE-1:0] address2,
  output wire  [WORD_SIZE-1:0] data2
);

  typedef enum logic [2:0] {IDLE, REQ, XFER, DONE, RELEASE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LENGTH - 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [WORD_SIZE-1:0] base;
  logic                 br_q;
  logic                 busy_q;
  logic                 irq_q;
  logic                 drive_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      base   <= '0;
      br_q   <= 1'b0;
      busy_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            base   <= bus.cmd_addr;
            cnt    <= '0;
            br_q   <= 1'b1;
            busy_q <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          if (bus.BG) state <= XFER;
        end
        XFER: begin
          // A word only retires when we actually own the bus; acks without grant belong to the CPU.
          if (bus.BG && bus.mem_ack) begin
            if (cnt == LAST) begin
              br_q  <= 1'b0;
              irq_q <= 1'b1;
              state <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          irq_q <= 1'b0;
          state <= RELEASE;
        end
        RELEASE: begin
          if (!bus.BG) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Follows BG combinationally so the port is released the moment the CPU revokes the grant.
  assign drive_en              = (state == XFER) && bus.BG;
  assign bus.writeM2           = drive_en;
  assign bus.BR                = br_q;
  assign bus.busy              = busy_q;
  assign bus.dma_end_interrupt = irq_q;
  assign bus.dev_index         = cnt;
  assign address2              = drive_en ? base + WORD_SIZE'(cnt) : 'z;
  assign data2                 = drive_en ? bus.dev_data : 'z;

endmodule

// File: tb/tb_dma_controller.sv
// tb/tb_dma_controller.sv - directed/randomized bench for dma_controller against a word-list model
module tb_dma_controller;
  localparam int W  = 16;
  localparam int L  = 12;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dma_if #(.WORD_SIZE(W), .CNT_W(CW)) bus ();
  wire [W-1:0] address2;
  wire [W-1:0] data2;
  logic [W-1:0] dev_buf [16];
  int compared = 0;
  int mismatched = 0;

  assign bus.dev_data = dev_buf[bus.dev_index];

  dma_controller #(.WORD_SIZE(W), .LENGTH(L), .CNT_W(CW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .address2 (address2),
    .data2    (data2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transfer: the model is simply "word i goes to base+i carrying dev_buf[i], once each".
  task automatic run_xfer(input logic [W-1:0] base, input int ack_mode, input bit revoke,
                          input bit extra_cmd, input bit do_reset);
    int words;
    int cyc;
    int gap;
    int hold;
    int grant_wait;
    bit bg;
    bit ack;
    for (int i = 0; i < 16; i++) dev_buf[i] = W'($urandom);
    @(negedge clk);
    bus.BG = 1'b0; bus.mem_ack = 1'b0;
    #1;
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_br", 32'(bus.BR), 32'd0);
    bus.cmd_valid = 1'b1; bus.cmd_addr = base;
    @(negedge clk);
    bus.cmd_valid = 1'b0; bus.cmd_addr = W'($urandom);
    grant_wait = $urandom_range(0, 2);
    for (int k = 0; k <= grant_wait; k++) begin
      if (k > 0) @(negedge clk);
      bus.BG = (k == grant_wait);
      bus.mem_ack = 1'($urandom);
      #1;
      chk("req_br", 32'(bus.BR), 32'd1);
      chk("req_busy", 32'(bus.busy), 32'd1);
      chk("req_wr", 32'(bus.writeM2), 32'd0);
    end
    words = 0; cyc = 0; gap = 0;
    while (words < L && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (do_reset && words == 7) begin
        reset_n = 1'b0;
        #1;
        chk("rst_br", 32'(bus.BR), 32'd0);
        chk("rst_wr", 32'(bus.writeM2), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_idx", 32'(bus.dev_index), 32'd0);
        bus.BG = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          #1;
          chk("rst_no_irq", 32'(bus.dma_end_interrupt), 32'd0);
          chk("rst_idle_br", 32'(bus.BR), 32'd0);
        end
        return;
      end
      bg = (gap == 0);
      if (gap > 0) gap--;
      case (ack_mode)
        0:       ack = 1'b1;
        1:       ack = (cyc % 4 == 0);
        default: ack = 1'($urandom);
      endcase
      bus.BG = bg; bus.mem_ack = ack;
      if (extra_cmd && cyc == 3) begin
        bus.cmd_valid = 1'b1; bus.cmd_addr = W'($urandom);
      end else begin
        bus.cmd_valid = 1'b0;
      end
      #1;
      chk("xfer_wr", 32'(bus.writeM2), 32'(bg));
      chk("xfer_br", 32'(bus.BR), 32'd1);
      chk("xfer_irq", 32'(bus.dma_end_interrupt), 32'd0);
      if (bg) begin
        chk("xfer_addr", 32'(address2), 32'(W'(base + W'(words))));
        chk("xfer_data", 32'(data2), 32'(dev_buf[words]));
      end
      if (bg && ack) begin
        words++;
        if (revoke && words == 6) gap = 3;
      end
    end
    chk("xfer_words", 32'(words), 32'(L));
    if (words != L) begin
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      return;
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.mem_ack = 1'($urandom);
    hold = $urandom_range(0, 3);
    #1;
    chk("done_irq", 32'(bus.dma_end_interrupt), 32'd1);
    chk("done_br", 32'(bus.BR), 32'd0);
    chk("done_wr", 32'(bus.writeM2), 32'd0);
    chk("done_busy", 32'(bus.busy), 32'd1);
    for (int k = 0; k <= hold; k++) begin
      @(negedge clk);
      bus.BG = (k < hold);
      #1;
      chk("rel_busy", 32'(bus.busy), 32'd1);
      chk("rel_br", 32'(bus.BR), 32'd0);
      chk("rel_irq", 32'(bus.dma_end_interrupt), 32'd0);
      chk("rel_wr", 32'(bus.writeM2), 32'd0);
    end
    @(negedge clk);
    #1;
    chk("end_busy", 32'(bus.busy), 32'd0);
    chk("end_irq", 32'(bus.dma_end_interrupt), 32'd0);
  endtask

  initial begin
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 16'h5555;
    bus.BG        = 1'b0;
    bus.mem_ack   = 1'b0;
    for (int i = 0; i < 16; i++) dev_buf[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state_br", 32'(bus.BR), 32'd0);
    chk("rst_state_wr", 32'(bus.writeM2), 32'd0);
    chk("rst_state_busy", 32'(bus.busy), 32'd0);
    chk("rst_state_irq", 32'(bus.dma_end_interrupt), 32'd0);
    chk("rst_state_idx", 32'(bus.dev_index), 32'd0);
    bus.cmd_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_br", 32'(bus.BR), 32'd0);

    run_xfer(16'h0017, 0, 1'b0, 1'b0, 1'b0);
    run_xfer(16'h1234, 1, 1'b0, 1'b0, 1'b0);
    run_xfer(16'h0200, 0, 1'b1, 1'b0, 1'b0);
    run_xfer(16'h4000, 0, 1'b0, 1'b1, 1'b0);
    run_xfer(16'hFFFA, 2, 1'b0, 1'b0, 1'b0);
    run_xfer(16'h0100, 0, 1'b0, 1'b0, 1'b1);
    run_xfer(16'h0017, 0, 1'b0, 1'b0, 1'b0);
    for (int t = 0; t < 4; t++)
      run_xfer(W'($urandom), 2, 1'($urandom), 1'($urandom), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
